// File: rtl/uart_rx.sv
// uart_rx -- asynchronous serial receiver, 1 start bit, DATA_W data bits
// (LSB first), 1 stop bit, no parity.
//
// Ports:
//   clk            system clock, all logic on its rising edge
//   rst            asynchronous active-high reset
//   uart_cnt       clocks per bit period, captured when a start edge is seen
//   uart_rxd       serial line, asynchronous to clk, idles high
//   uart_data      last correctly received word, held until the next good frame
//   uart_flag      one-cycle pulse when uart_data has just been updated
//   uart_busy      high whenever the receiver is not idle
//   uart_frame_err one-cycle pulse when the stop bit was sampled low
module uart_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       uart_cnt,
    input  logic              uart_rxd,
    output logic [DATA_W-1:0] uart_data,
    output logic              uart_flag,
    output logic              uart_busy,
    output logic              uart_frame_err
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t state;
    state_t state_nx;

    logic              rxd_m;
    logic              rxd_s;
    logic              rxd_d;
    logic [15:0]       nl;
    logic [15:0]       cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;

    logic fall;
    logic half_hit;
    logic full_hit;
    logic last_bit;
    logic start_det;
    logic start_ok;
    logic bit_take;
    logic stop_good;
    logic stop_bad;

    assign fall      = rxd_d & ~rxd_s;
    assign half_hit  = (cnt == ((nl >> 1) - 16'd1));
    assign full_hit  = (cnt == (nl - 16'd1));
    assign last_bit  = (bit_cnt == BW'(DATA_W - 1));
    assign uart_busy = (state != IDLE);

    // Synchronizer flops reset low so a line held low through reset
    // release never looks like a high-to-low transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b0;
            rxd_s <= 1'b0;
            rxd_d <= 1'b0;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        start_det = 1'b0;
        start_ok  = 1'b0;
        bit_take  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    start_det = 1'b1;
                    state_nx  = START;
                end
            end
            START: begin
                // Mid-start-bit recheck: a line back high here was a glitch.
                if (half_hit) begin
                    if (!rxd_s) begin
                        start_ok = 1'b1;
                        state_nx = DATA;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (full_hit) begin
                    bit_take = 1'b1;
                    if (last_bit) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (full_hit) begin
                    if (rxd_s) begin
                        stop_good = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line is a break, not a new start; wait it out.
                if (rxd_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bit period is frozen at start detection so uart_cnt may change freely
    // mid-frame; periods below 4 clocks are forced up to 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nl      <= 16'd4;
            cnt     <= 16'd0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (start_det) begin
                nl <= (uart_cnt < 16'd4) ? 16'd4 : uart_cnt;
            end
            if (start_det || start_ok || bit_take) begin
                cnt <= 16'd0;
            end else if (state == START || state == DATA || state == STOP) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= 16'd0;
            end
            if (start_ok) begin
                bit_cnt <= '0;
            end else if (bit_take) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            if (bit_take) begin
                shreg <= {rxd_s, shreg[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_data      <= '0;
            uart_flag      <= 1'b0;
            uart_frame_err <= 1'b0;
        end else begin
            uart_flag      <= stop_good;
            uart_frame_err <= stop_bad;
            if (stop_good) begin
                uart_data <= shreg;
            end
        end
    end

endmodule
